// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl
//   Multicycle RV32I control FSM. It steps each instruction through fetch,
//   decode, execute, memory and writeback states, and drives the datapath
//   mux selects and write strobes. It stalls on the mem_ready handshake,
//   flags illegal opcodes, and counts retired instructions.
// Ports:
//   clk, reset      - clock; synchronous active-high reset
//   opcode          - instr[6:0] from the instruction register
//   mem_ready       - memory access completes this cycle
//   PCUpdate, Branch, RegWrite, MemWrite, IRWrite - write strobes
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc - datapath selects
//   illegal_instr   - one-cycle pulse in TRAP
//   state_o         - current state code (debug)
//   instret         - retired-instruction count
module riscv_multicycle_ctrl #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ILLEGAL_TRAP  = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             PCUpdate,
  output logic             Branch,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [2:0]       ImmSrc,
  output logic             illegal_instr,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             ready, retire;
  logic             pc_upd, br, rw, mw, irw, ill;

  // Without the handshake every memory access completes in one cycle.
  assign ready   = mem_ready | ~MEM_HANDSHAKE;
  assign state_o = state_q;
  assign instret = instret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    pc_upd    = 1'b0;
    br        = 1'b0;
    rw        = 1'b0;
    mw        = 1'b0;
    irw       = 1'b0;
    ill       = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (ready) begin
          irw     = 1'b1;
          pc_upd  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // OldPC+imm lands in ALUOut for branch/JAL/AUIPC targets.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_IMM:            state_d = S_EXECI;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALUWB;
          default: begin
            if (ILLEGAL_TRAP) begin
              state_d = S_TRAP;
            end else begin
              // Unknown opcode retires as a NOP.
              state_d = S_FETCH;
              retire  = 1'b1;
            end
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rw        = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_MEMWRITE: begin
        // The write strobe is held through every wait cycle.
        AdrSrc = 1'b1;
        mw     = 1'b1;
        if (ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rw      = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        br      = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_JAL: begin
        // The PC takes the target from ALUOut; the ALU forms OldPC+4 as the link value.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_upd  = 1'b1;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JAL;
      end
      S_LUI: begin
        ResultSrc = 2'b11;
        rw        = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_TRAP: begin
        ill     = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
  end

  // Strobes are suppressed for the whole reset cycle, not just after the edge.
  always_comb begin
    PCUpdate      = pc_upd & ~reset;
    Branch        = br     & ~reset;
    RegWrite      = rw     & ~reset;
    MemWrite      = mw     & ~reset;
    IRWrite       = irw    & ~reset;
    illegal_instr = ill    & ~reset;
  end

  always_comb begin
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: ImmSrc = 3'b000;
      OP_STORE:                 ImmSrc = 3'b001;
      OP_BR:                    ImmSrc = 3'b010;
      OP_JAL:                   ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC:         ImmSrc = 3'b100;
      default:                  ImmSrc = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Bench for riscv_multicycle_ctrl. The main instance runs with default
// parameters against an instruction-level model. The model knows each
// instruction class's state path and each state's output table. A second
// instance (no handshake, no trap) is checked against literal expectations.
module tb_riscv_multicycle_ctrl;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mem_ready;
  logic [6:0]  opcode;
  logic        PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc, illegal_instr;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0]  ImmSrc;
  logic [3:0]  state_o;
  logic [31:0] instret;

  riscv_multicycle_ctrl #(.MEM_HANDSHAKE(1'b1), .ILLEGAL_TRAP(1'b1), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCUpdate(PCUpdate), .Branch(Branch), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .illegal_instr(illegal_instr),
    .state_o(state_o), .instret(instret)
  );

  logic        reset2, mem_ready2;
  logic [6:0]  opcode2;
  logic        pcu2, br2, rw2, mw2, irw2, adr2, ill2;
  logic [1:0]  rs2, sa2, sb2, aop2;
  logic [2:0]  imm2;
  logic [3:0]  st2;
  logic [7:0]  ir2;

  riscv_multicycle_ctrl #(.MEM_HANDSHAKE(1'b0), .ILLEGAL_TRAP(1'b0), .CNT_W(8)) u_dut_nt (
    .clk(clk), .reset(reset2), .opcode(opcode2), .mem_ready(mem_ready2),
    .PCUpdate(pcu2), .Branch(br2), .RegWrite(rw2), .MemWrite(mw2),
    .IRWrite(irw2), .AdrSrc(adr2), .ResultSrc(rs2), .ALUSrcA(sa2),
    .ALUSrcB(sb2), .ALUOp(aop2), .ImmSrc(imm2), .illegal_instr(ill2),
    .state_o(st2), .instret(ir2)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic        rdy;
    logic        rst;
    logic [6:0]  op;
    logic [31:0] ir;
  } exp_t;

  exp_t q[$];
  int   path[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   instret_m = 0;
  bit   done2 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    if (op == OP_LOAD || op == OP_IMM || op == OP_JALR) return 3'b000;
    if (op == OP_STORE) return 3'b001;
    if (op == OP_BR)    return 3'b010;
    if (op == OP_JAL)   return 3'b011;
    if (op == OP_LUI || op == OP_AUIPC) return 3'b100;
    return 3'b000;
  endfunction

  // Output table per state:
  // {PCUpdate,Branch,RegWrite,MemWrite,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,illegal}
  function automatic logic [17:0] exp_ctrl(input exp_t e);
    logic pcu, brn, rw, mw, irw, adr, ill;
    logic [1:0] rs, sa, sb, aop;
    int s;
    s   = int'(e.st);
    pcu = (s == 0 && e.rdy) || s == 10;
    irw = (s == 0 && e.rdy);
    rw  = (s == 4 || s == 8 || s == 12);
    mw  = (s == 5);
    brn = (s == 9);
    ill = (s == 13);
    adr = (s == 3 || s == 5);
    rs  = (s == 0) ? 2'b10 : (s == 4) ? 2'b01 : (s == 12) ? 2'b11 : 2'b00;
    sa  = (s == 1 || s == 10) ? 2'b01 :
          (s == 2 || s == 6 || s == 7 || s == 9 || s == 11) ? 2'b10 : 2'b00;
    sb  = (s == 0 || s == 10) ? 2'b10 :
          (s == 1 || s == 2 || s == 7 || s == 11) ? 2'b01 : 2'b00;
    aop = (s == 6 || s == 7) ? 2'b10 : (s == 9) ? 2'b01 : 2'b00;
    if (e.rst) {pcu, brn, rw, mw, irw, ill} = '0;
    return {pcu, brn, rw, mw, irw, adr, rs, sa, sb, aop, imm_of(e.op), ill};
  endfunction

  // State path of each instruction class, no waits.
  function automatic void make_path(input logic [6:0] op);
    path.delete();
    path.push_back(0);
    path.push_back(1);
    case (op)
      OP_R:     begin path.push_back(6);  path.push_back(8); end
      OP_IMM:   begin path.push_back(7);  path.push_back(8); end
      OP_AUIPC: path.push_back(8);
      OP_LOAD:  begin path.push_back(2);  path.push_back(3); path.push_back(4); end
      OP_STORE: begin path.push_back(2);  path.push_back(5); end
      OP_BR:    path.push_back(9);
      OP_JAL:   begin path.push_back(10); path.push_back(8); end
      OP_JALR:  begin path.push_back(11); path.push_back(10); path.push_back(8); end
      OP_LUI:   path.push_back(12);
      default:  path.push_back(13);
    endcase
  endfunction

  task automatic step(input int s, input logic rdy, input logic rst);
    exp_t e;
    mem_ready = rdy;
    reset     = rst;
    e.st  = s[3:0];
    e.rdy = rdy;
    e.rst = rst;
    e.op  = opcode;
    e.ir  = instret_m;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Non-memory states run with mem_ready low to show they never stall.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
    int s, w;
    opcode = op;
    make_path(op);
    foreach (path[i]) begin
      s = path[i];
      if (s == 0 || s == 3 || s == 5) begin
        w = (s == 0) ? fw : mw;
        repeat (w) step(s, 1'b0, 1'b0);
        step(s, 1'b1, 1'b0);
      end else begin
        step(s, 1'b0, 1'b0);
      end
    end
    if (path[path.size()-1] != 13) instret_m++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("state_o", {28'd0, state_o}, {28'd0, e.st});
      chk("ctrl", {14'd0, PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc,
                   ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal_instr},
          {14'd0, exp_ctrl(e)});
      chk("instret", instret, e.ir);
    end
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b0; opcode = 7'd0;
    @(posedge clk); #1;
    step(0, 1'b1, 1'b1);                 // reset holds FETCH, strobes forced 0
    run_instr(OP_R, 0, 0);
    chk("lit_instret_R", instret, 32'd1);
    run_instr(OP_LOAD, 0, 3);
    run_instr(OP_STORE, 0, 2);
    run_instr(OP_JALR, 0, 0);
    chk("lit_instret_jalr", instret, 32'd4);
    run_instr(OP_BAD, 0, 0);
    chk("lit_instret_trap", instret, 32'd4);
    run_instr(OP_IMM, 1, 0);
    run_instr(OP_AUIPC, 0, 0);
    run_instr(OP_BR, 0, 0);
    run_instr(OP_JAL, 2, 0);
    run_instr(OP_LUI, 0, 0);
    chk("lit_instret_lui", instret, 32'd9);
    // Reset in the middle of a stalled load abandons it.
    opcode = OP_LOAD;
    step(0, 1'b1, 1'b0);
    step(1, 1'b0, 1'b0);
    step(2, 1'b0, 1'b0);
    step(3, 1'b0, 1'b0);
    step(3, 1'b1, 1'b1);
    instret_m = 0;
    step(0, 1'b1, 1'b1);
    chk("lit_instret_reset", instret, 32'd0);
    run_instr(OP_R, 0, 0);
    chk("lit_instret_after_reset", instret, 32'd1);
    @(negedge clk);
    for (int i = 0; i < 200 && !done2; i++) @(posedge clk);
    chk("nt_done", {31'd0, done2}, 32'd1);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // No-handshake / no-trap instance: literal expectations.
  initial begin
    reset2 = 1'b1; mem_ready2 = 1'b0; opcode2 = OP_BAD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset2 = 1'b0;
    chk("nt_fetch_state", {28'd0, st2}, 32'd0);
    chk("nt_fetch_irwrite", {31'd0, irw2}, 32'd1);
    @(posedge clk); #1;
    chk("nt_decode_state", {28'd0, st2}, 32'd1);
    @(posedge clk); #1;
    chk("nt_nop_state", {28'd0, st2}, 32'd0);
    chk("nt_nop_instret", {24'd0, ir2}, 32'd1);
    opcode2 = OP_LOAD;
    @(posedge clk); #1;
    chk("nt_ld_decode", {28'd0, st2}, 32'd1);
    @(posedge clk); #1;
    chk("nt_ld_memadr", {28'd0, st2}, 32'd2);
    @(posedge clk); #1;
    chk("nt_ld_memread", {28'd0, st2}, 32'd3);
    @(posedge clk); #1;
    chk("nt_ld_memwb", {28'd0, st2}, 32'd4);
    @(posedge clk); #1;
    chk("nt_ld_fetch", {28'd0, st2}, 32'd0);
    chk("nt_ld_instret", {24'd0, ir2}, 32'd2);
    done2 = 1'b1;
  end

endmodule
